// File: rtl/vscale_hasti_sram_slave_pkg.sv
// Shared HASTI bus constants, the latched control struct and the byte-enable helper
// used by the SRAM slave.
package vscale_hasti_sram_slave_pkg;

    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_TRANS_WIDTH = 2;
    localparam int HASTI_RESP_WIDTH  = 1;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;

    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE     = 3'd0;
    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALFWORD = 3'd1;
    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD     = 3'd2;

    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

    typedef struct packed {
        logic [HASTI_ADDR_WIDTH-1:0] addr;
        logic                        write;
        logic [HASTI_SIZE_WIDTH-1:0] size;
    } hasti_ctrl_t;

    // Lanes touched by an aligned access; misaligned/oversize never reach here.
    function automatic logic [NUM_LANES-1:0] hasti_byte_en(
        input logic [HASTI_SIZE_WIDTH-1:0] size,
        input logic [1:0]                  lo
    );
        logic [NUM_LANES-1:0] be;
        be = '0;
        case (size)
            HASTI_SIZE_BYTE:     be[lo] = 1'b1;
            HASTI_SIZE_HALFWORD: be = lo[1] ? 4'b1100 : 4'b0011;
            HASTI_SIZE_WORD:     be = 4'b1111;
            default:             be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/vscale_hasti_sram_slave_if.sv
// HASTI (AHB-lite) bus bundle between one master and the SRAM slave.
interface vscale_hasti_sram_slave_if;
    import vscale_hasti_sram_slave_pkg::*;

    logic [HASTI_ADDR_WIDTH-1:0]  haddr;
    logic                         hwrite;
    logic [HASTI_SIZE_WIDTH-1:0]  hsize;
    logic [HASTI_BURST_WIDTH-1:0] hburst;
    logic                         hmastlock;
    logic [HASTI_PROT_WIDTH-1:0]  hprot;
    logic [HASTI_TRANS_WIDTH-1:0] htrans;
    logic [HASTI_BUS_WIDTH-1:0]   hwdata;
    logic [HASTI_BUS_WIDTH-1:0]   hrdata;
    logic                         hready;
    logic [HASTI_RESP_WIDTH-1:0]  hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/vscale_hasti_sram_slave_array.sv
// DEPTH x 32 storage split into byte lanes; synchronous per-lane write, async read.
module vscale_sram_array
    import vscale_hasti_sram_slave_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic [AW-1:0]                       waddr,
    input  logic [NUM_LANES-1:0]                we,
    input  logic [NUM_LANES-1:0][VEC_W-1:0]     wdata,
    input  logic [AW-1:0]                       raddr,
    output logic [NUM_LANES-1:0][VEC_W-1:0]     rdata
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [VEC_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we[i]) mem[waddr] <= wdata[i];
        end

        assign rdata[i] = mem[raddr];
    end

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// Always-selected HASTI SRAM slave: optional data-phase wait states, two-cycle ERROR
// response for out-of-range or misaligned accesses, full-word read data.
module vscale_hasti_sram_slave
    import vscale_hasti_sram_slave_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    vscale_hasti_sram_slave_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    hasti_ctrl_t ctrl_q, ctrl_d;

    logic                               hready_w;
    logic [HASTI_RESP_WIDTH-1:0]        hresp_w;
    logic [HASTI_BUS_WIDTH-1:0]         hrdata_w;
    logic [31:0]                        word_idx;
    logic                               legal;
    logic                               accept;
    logic                               data_end;
    logic [NUM_LANES-1:0]               we;
    logic [NUM_LANES-1:0][VEC_W-1:0]    wdata;
    logic [NUM_LANES-1:0][VEC_W-1:0]    rdata;

    always_comb begin
        word_idx = {2'b00, bus.haddr[31:2]};
        legal    = word_idx < 32'(DEPTH);
        case (bus.hsize)
            HASTI_SIZE_BYTE:     ;
            HASTI_SIZE_HALFWORD: if (bus.haddr[0]) legal = 1'b0;
            HASTI_SIZE_WORD:     if (bus.haddr[1:0] != 2'b00) legal = 1'b0;
            default:             legal = 1'b0;
        endcase
    end

    assign data_end = (state_q == S_DATA) && (cnt_q == 4'd0);
    assign accept   = hready_w && ((bus.htrans == HASTI_TRANS_NONSEQ) ||
                                   (bus.htrans == HASTI_TRANS_SEQ));

    always_comb begin
        hready_w = 1'b1;
        hresp_w  = HASTI_RESP_OKAY;
        hrdata_w = '0;
        case (state_q)
            S_DATA: begin
                hready_w = data_end;
                if (data_end && !ctrl_q.write) hrdata_w = rdata;
            end
            S_ERR1: begin
                hready_w = 1'b0;
                hresp_w  = HASTI_RESP_ERROR;
            end
            S_ERR2:  hresp_w = HASTI_RESP_ERROR;
            default: ;
        endcase
    end

    // Every edge with hready high doubles as the next address phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            S_DATA: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else state_d = S_IDLE;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            ctrl_d  = '{addr: bus.haddr, write: bus.hwrite, size: bus.hsize};
            state_d = legal ? S_DATA : S_ERR1;
            cnt_d   = legal ? 4'(WAIT_STATES) : 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign we    = (data_end && ctrl_q.write) ? hasti_byte_en(ctrl_q.size, ctrl_q.addr[1:0]) : '0;
    assign wdata = bus.hwdata;

    vscale_sram_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .waddr (ctrl_q.addr[AW+1:2]),
        .we    (we),
        .wdata (wdata),
        .raddr (ctrl_q.addr[AW+1:2]),
        .rdata (rdata)
    );

    assign bus.hready = hready_w;
    assign bus.hresp  = hresp_w;
    assign bus.hrdata = hrdata_w;

    logic unused_ok;
    assign unused_ok = ^{bus.hburst, bus.hmastlock, bus.hprot, ctrl_q.addr[HASTI_ADDR_WIDTH-1:AW+2]};

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Bench for the HASTI SRAM slave: one zero-wait and one three-wait instance driven
// by directed steps and random traffic, checked against a word-array model.
module tb_vscale_hasti_sram_slave;
    import vscale_hasti_sram_slave_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst0, rst3;
    always #5 clk = ~clk;

    vscale_hasti_sram_slave_if bus0 ();
    vscale_hasti_sram_slave_if bus3 ();

    vscale_hasti_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0.slave));
    vscale_hasti_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(rst3), .bus(bus3.slave));

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    int checks = 0;
    int failures = 0;
    logic [31:0] m0 [DEPTH];
    logic [31:0] m3 [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2]) % DEPTH;
    endfunction

    // Bytes [lo, lo + 2**size) of the word take the same lanes of wdata.
    function automatic logic [31:0] merge(input logic [31:0] old, input op_t op);
        logic [31:0] r = old;
        int lo = int'(op.addr[1:0]);
        int n  = 1 << op.size;
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + n) r[8*b +: 8] = op.wdata[8*b +: 8];
        return r;
    endfunction

    function automatic op_t mk(input bit wr, input logic [31:0] a, input logic [2:0] s,
                               input logic [31:0] d);
        op_t o;
        o.wr = wr; o.addr = a; o.size = s; o.wdata = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        int s  = $urandom_range(0, 2);
        int ix = $urandom_range(0, DEPTH - 1);
        int lo = (s == 0) ? $urandom_range(0, 3) : (s == 1) ? 2 * $urandom_range(0, 1) : 0;
        return mk(1'($urandom_range(0, 1)), 32'(ix * 4 + lo), 3'(s), $urandom());
    endfunction

    task automatic idle_bus();
        bus0.htrans = HASTI_TRANS_IDLE; bus0.haddr = '0; bus0.hwrite = 1'b0;
        bus0.hsize = HASTI_SIZE_WORD;   bus0.hwdata = '0; bus0.hburst = '0;
        bus0.hmastlock = 1'b0;          bus0.hprot = '0;
        bus3.htrans = HASTI_TRANS_IDLE; bus3.haddr = '0; bus3.hwrite = 1'b0;
        bus3.hsize = HASTI_SIZE_WORD;   bus3.hwdata = '0; bus3.hburst = '0;
        bus3.hmastlock = 1'b0;          bus3.hprot = '0;
    endtask

    // Issue legal ops back to back on the zero-wait slave, one per cycle.
    task automatic run0(input op_t ops[$]);
        op_t dp;
        bit  dpv = 1'b0;
        int  i = 0;
        while (i < ops.size() || dpv) begin
            if (i < ops.size()) begin
                bus0.htrans = (i % 2) ? HASTI_TRANS_SEQ : HASTI_TRANS_NONSEQ;
                bus0.haddr  = ops[i].addr;
                bus0.hwrite = ops[i].wr;
                bus0.hsize  = ops[i].size;
            end else begin
                bus0.htrans = HASTI_TRANS_IDLE;
            end
            bus0.hwdata = dpv ? dp.wdata : $urandom();
            if (dpv) begin
                chk("b2b_hready", 32'(bus0.hready), 32'd1);
                chk("b2b_hresp", 32'(bus0.hresp), 32'd0);
                if (dp.wr) m0[widx(dp.addr)] = merge(m0[widx(dp.addr)], dp);
                else chk($sformatf("b2b_rdata@%h", dp.addr), bus0.hrdata, m0[widx(dp.addr)]);
            end
            dpv = (i < ops.size());
            if (dpv) begin
                dp = ops[i];
                i++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Illegal access on slave 0, then a read of the aliased word in the ERR2 address phase.
    task automatic err0(input bit wr, input logic [31:0] a, input logic [2:0] s);
        logic [31:0] va;
        va = {a[31:2] % 32'(DEPTH), 2'b00};
        bus0.htrans = HASTI_TRANS_NONSEQ; bus0.haddr = a; bus0.hwrite = wr; bus0.hsize = s;
        @(posedge clk); #1;
        bus0.htrans = HASTI_TRANS_IDLE; bus0.hwdata = $urandom();
        chk("err1_hready", 32'(bus0.hready), 32'd0);
        chk("err1_hresp", 32'(bus0.hresp), 32'd1);
        chk("err1_hrdata", bus0.hrdata, 32'd0);
        @(posedge clk); #1;
        chk("err2_hready", 32'(bus0.hready), 32'd1);
        chk("err2_hresp", 32'(bus0.hresp), 32'd1);
        chk("err2_hrdata", bus0.hrdata, 32'd0);
        bus0.htrans = HASTI_TRANS_NONSEQ; bus0.haddr = va; bus0.hwrite = 1'b0;
        bus0.hsize = HASTI_SIZE_WORD;
        @(posedge clk); #1;
        bus0.htrans = HASTI_TRANS_IDLE;
        chk("after_err_hready", 32'(bus0.hready), 32'd1);
        chk("after_err_hresp", 32'(bus0.hresp), 32'd0);
        chk($sformatf("after_err_rdata@%h", va), bus0.hrdata, m0[widx(va)]);
        @(posedge clk); #1;
    endtask

    // Single transfer on the three-wait slave; counts stall cycles with a bound.
    task automatic xfer3(input op_t op);
        int stall = 0;
        bus3.htrans = HASTI_TRANS_NONSEQ; bus3.haddr = op.addr; bus3.hwrite = op.wr;
        bus3.hsize = op.size;
        @(posedge clk); #1;
        bus3.htrans = HASTI_TRANS_IDLE; bus3.hwdata = op.wdata;
        while (bus3.hready !== 1'b1 && stall < 20) begin
            stall++;
            @(posedge clk); #1;
        end
        chk("ws_stall_cycles", 32'(stall), 32'd3);
        chk("ws_hresp", 32'(bus3.hresp), 32'd0);
        if (op.wr) m3[widx(op.addr)] = merge(m3[widx(op.addr)], op);
        else chk($sformatf("ws_rdata@%h", op.addr), bus3.hrdata, m3[widx(op.addr)]);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        op_t q[$];
        idle_bus();
        rst0 = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hready0", 32'(bus0.hready), 32'd1);
        chk("rst_hresp0", 32'(bus0.hresp), 32'd0);
        chk("rst_hrdata0", bus0.hrdata, 32'd0);
        chk("rst_hready3", 32'(bus3.hready), 32'd1);
        rst0 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;

        // Fill every word so the model has no unknowns.
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(mk(1'b1, 32'(i * 4), HASTI_SIZE_WORD, $urandom()));
        run0(q);

        q = {};
        q.push_back(mk(1'b1, 32'h10, HASTI_SIZE_WORD, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 32'h10, HASTI_SIZE_WORD, $urandom()));
        run0(q);
        chk("deadbeef_model", m0[4], 32'hDEADBEEF);

        q = {};
        q.push_back(mk(1'b1, 32'h10, HASTI_SIZE_WORD, 32'h11223344));
        q.push_back(mk(1'b1, 32'h13, HASTI_SIZE_BYTE, 32'hAA5A5A5A));
        q.push_back(mk(1'b0, 32'h10, HASTI_SIZE_WORD, $urandom()));
        q.push_back(mk(1'b1, 32'h1A, HASTI_SIZE_HALFWORD, 32'hBEEF1234));
        q.push_back(mk(1'b0, 32'h18, HASTI_SIZE_WORD, $urandom()));
        run0(q);
        chk("byte_merge_model", m0[4], 32'hAA223344);

        q = {};
        for (int i = 0; i < 300; i++) q.push_back(rand_op());
        for (int i = 0; i < DEPTH; i++) q.push_back(mk(1'b0, 32'(i * 4), HASTI_SIZE_WORD, $urandom()));
        run0(q);

        err0(1'b0, 32'h2, HASTI_SIZE_WORD);
        err0(1'b0, 32'(DEPTH * 4), HASTI_SIZE_WORD);
        err0(1'b1, 32'(DEPTH * 4), HASTI_SIZE_WORD);
        err0(1'b1, 32'h3, HASTI_SIZE_WORD);
        err0(1'b1, 32'h5, HASTI_SIZE_HALFWORD);
        err0(1'b1, 32'h8, 3'd3);

        // BUSY/IDLE with write-looking controls must not touch the array.
        bus0.haddr = 32'h10; bus0.hwrite = 1'b1; bus0.hsize = HASTI_SIZE_WORD;
        for (int i = 0; i < 6; i++) begin
            bus0.htrans = (i % 2) ? HASTI_TRANS_IDLE : HASTI_TRANS_BUSY;
            bus0.hwdata = $urandom();
            @(posedge clk); #1;
            chk("busy_hready", 32'(bus0.hready), 32'd1);
            chk("busy_hresp", 32'(bus0.hresp), 32'd0);
            chk("busy_hrdata", bus0.hrdata, 32'd0);
        end
        bus0.htrans = HASTI_TRANS_IDLE;
        q = {};
        q.push_back(mk(1'b0, 32'h10, HASTI_SIZE_WORD, $urandom()));
        run0(q);

        xfer3(mk(1'b1, 32'h20, HASTI_SIZE_WORD, 32'h5555AAAA));
        xfer3(mk(1'b0, 32'h20, HASTI_SIZE_WORD, $urandom()));
        xfer3(mk(1'b1, 32'h21, HASTI_SIZE_BYTE, 32'h0000C300));
        xfer3(mk(1'b0, 32'h20, HASTI_SIZE_WORD, $urandom()));

        // Reset in the middle of a stalled write: the write must be dropped.
        bus3.htrans = HASTI_TRANS_NONSEQ; bus3.haddr = 32'h20; bus3.hwrite = 1'b1;
        bus3.hsize = HASTI_SIZE_WORD;
        @(posedge clk); #1;
        bus3.htrans = HASTI_TRANS_IDLE; bus3.hwdata = 32'h0BADF00D;
        chk("stall_before_rst", 32'(bus3.hready), 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        chk("midrst_hready", 32'(bus3.hready), 32'd1);
        chk("midrst_hresp", 32'(bus3.hresp), 32'd0);
        chk("midrst_hrdata", bus3.hrdata, 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(posedge clk); #1;
        xfer3(mk(1'b0, 32'h20, HASTI_SIZE_WORD, $urandom()));
        chk("old_data_model", m3[8], 32'h5555C3AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
